// File: rtl/par_circular_buffer_pkg.sv
// Shared constants and helpers for the PE-array word buffers.
package par_circular_buffer_pkg;

  localparam int DATA_WIDTH = 20;
  localparam int BUF_DEPTH  = 60;

  // Ceiling log2. Returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Width of a pointer into a DEPTH-word array. Never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/par_circular_buffer_circ_ptr_inc.sv
// Modulo-DEPTH pointer advance by a fixed STEP. Wraps by comparing the
// incremented value against DEPTH and subtracting, so DEPTH may be any
// integer, not only a power of two.
module circ_ptr_inc
  import par_circular_buffer_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int STEP  = 1,
  parameter int PTR_W = ptr_width(DEPTH)
) (
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] ptr_next
);

  // One extra bit holds ptr+STEP, which can reach 2*DEPTH-1 at most.
  localparam logic [PTR_W:0] STEP_EXT  = STEP[PTR_W:0];
  localparam logic [PTR_W:0] DEPTH_EXT = DEPTH[PTR_W:0];

  logic [PTR_W:0] sum;

  // Add the step, then fold back into 0..DEPTH-1 with a single subtract.
  always_comb begin
    sum = {1'b0, ptr} + STEP_EXT;
    if (sum >= DEPTH_EXT) begin
      ptr_next = PTR_W'(sum - DEPTH_EXT);
    end else begin
      ptr_next = PTR_W'(sum);
    end
  end

endmodule

// File: rtl/par_circular_buffer.sv
// Circular word buffer with parallel push (PAR_WRITE words) and parallel
// first-word-fall-through pop (PAR_READ words). Slice 0 of din and dout is
// always the oldest word. Storage is never cleared; reset and flush only
// rewind the pointers and the occupancy count.
module par_circular_buffer
  import par_circular_buffer_pkg::*;
#(
  parameter int BITS      = DATA_WIDTH,
  parameter int DEPTH     = BUF_DEPTH,
  parameter int PAR_WRITE = 1,
  parameter int PAR_READ  = 1,
  parameter int CNT_W     = clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_en,
  input  logic [PAR_WRITE*BITS-1:0] din,
  input  logic                      read_en,
  input  logic                      flush,
  output logic [PAR_READ*BITS-1:0]  dout,
  output logic                      ready,
  output logic                      valid,
  output logic [CNT_W-1:0]          count,
  output logic                      err
);

  localparam int PTR_W = ptr_width(DEPTH);

  localparam logic [CNT_W-1:0] WRITE_STEP = CNT_W'(PAR_WRITE);
  localparam logic [CNT_W-1:0] READ_STEP  = CNT_W'(PAR_READ);
  localparam logic [CNT_W-1:0] FREE_LIMIT = CNT_W'(DEPTH - PAR_WRITE);

  logic [BITS-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [PTR_W-1:0] wr_addr [PAR_WRITE];
  logic [PTR_W-1:0] rd_addr [PAR_READ];
  logic             do_write;
  logic             do_read;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] count_dec;

  // Base pointer plus a small lane offset, folded into 0..DEPTH-1.
  function automatic logic [PTR_W-1:0] wrap_offset(input logic [PTR_W-1:0] base,
                                                   input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= DEPTH) begin
      sum = sum - DEPTH;
    end
    return PTR_W'(sum);
  endfunction

  circ_ptr_inc #(
    .DEPTH (DEPTH),
    .STEP  (PAR_WRITE),
    .PTR_W (PTR_W)
  ) u_wr_inc (
    .ptr      (wr_ptr),
    .ptr_next (wr_ptr_next)
  );

  circ_ptr_inc #(
    .DEPTH (DEPTH),
    .STEP  (PAR_READ),
    .PTR_W (PTR_W)
  ) u_rd_inc (
    .ptr      (rd_ptr),
    .ptr_next (rd_ptr_next)
  );

  // Space and data flags look only at the registered count.
  always_comb begin
    ready = (count <= FREE_LIMIT);
    valid = (count >= READ_STEP);
  end

  // Accept decisions; reset and flush suppress both directions.
  always_comb begin
    do_write  = write_en && ready && !rst && !flush;
    do_read   = read_en && valid && !rst && !flush;
    count_inc = do_write ? WRITE_STEP : '0;
    count_dec = do_read ? READ_STEP : '0;
  end

  // Per-lane memory addresses for the write and read windows.
  always_comb begin
    for (int i = 0; i < PAR_WRITE; i++) begin
      wr_addr[i] = wrap_offset(wr_ptr, i);
    end
    for (int i = 0; i < PAR_READ; i++) begin
      rd_addr[i] = wrap_offset(rd_ptr, i);
    end
  end

  // Fall-through read window: the oldest PAR_READ words, slice 0 first.
  always_comb begin
    dout = '0;
    for (int i = 0; i < PAR_READ; i++) begin
      dout[i*BITS +: BITS] = mem[rd_addr[i]];
    end
  end

  // Storage write; deliberately has no reset so contents survive flush/rst.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        mem[wr_addr[i]] <= din[i*BITS +: BITS];
      end
    end
  end

  // Pointers, occupancy and sticky error; reset beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr_next;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr_next;
      end
      count <= count + count_inc - count_dec;
      if ((write_en && !ready) || (read_en && !valid)) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_par_circular_buffer.sv
// Directed bench: a 6-deep, 2-in/3-out instance for the parallel cases and a
// 60-deep, 1-in/1-out instance for the tagged streaming case.
module tb_par_circular_buffer;

  localparam int BITS = 22;

  logic clk;
  logic rst;

  logic              a_write_en;
  logic [2*BITS-1:0] a_din;
  logic              a_read_en;
  logic              a_flush;
  logic [3*BITS-1:0] a_dout;
  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_count;
  logic              a_err;

  logic            b_write_en;
  logic [BITS-1:0] b_din;
  logic            b_read_en;
  logic            b_flush;
  logic [BITS-1:0] b_dout;
  logic            b_ready;
  logic            b_valid;
  logic [5:0]      b_count;
  logic            b_err;

  int checks;
  int failures;

  par_circular_buffer #(
    .BITS (BITS), .DEPTH (6), .PAR_WRITE (2), .PAR_READ (3)
  ) u_dut_a (
    .clk (clk), .rst (rst), .write_en (a_write_en), .din (a_din),
    .read_en (a_read_en), .flush (a_flush), .dout (a_dout),
    .ready (a_ready), .valid (a_valid), .count (a_count), .err (a_err)
  );

  par_circular_buffer #(
    .BITS (BITS), .DEPTH (60), .PAR_WRITE (1), .PAR_READ (1)
  ) u_dut_b (
    .clk (clk), .rst (rst), .write_en (b_write_en), .din (b_din),
    .read_en (b_read_en), .flush (b_flush), .dout (b_dout),
    .ready (b_ready), .valid (b_valid), .count (b_count), .err (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [65:0] observed,
                             input logic [65:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock of stimulus on the 2-in/3-out instance; outputs are sampled
  // 1ns after the edge by the caller.
  task automatic applyStimulus(input logic we, input logic [2*BITS-1:0] d,
                               input logic re, input logic fl);
    a_write_en = we;
    a_din      = d;
    a_read_en  = re;
    a_flush    = fl;
    @(posedge clk);
    #1;
    a_write_en = 1'b0;
    a_read_en  = 1'b0;
    a_flush    = 1'b0;
  endtask

  task automatic applyStimulusB(input logic we, input logic [BITS-1:0] d,
                                input logic re);
    b_write_en = we;
    b_din      = d;
    b_read_en  = re;
    @(posedge clk);
    #1;
    b_write_en = 1'b0;
    b_read_en  = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [1:0] tagFor(input int k);
    case (k)
      0: return 2'b10;
      1: return 2'b00;
      2: return 2'b11;
      3: return 2'b01;
      4: return 2'b10;
      5: return 2'b11;
      6: return 2'b00;
      7: return 2'b10;
      8: return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [BITS-1:0] wordFor(input int k);
    return {tagFor(k), 20'(k * 4099 + 17)};
  endfunction

  function automatic logic [2*BITS-1:0] pair(input int hi, input int lo);
    return {BITS'(hi), BITS'(lo)};
  endfunction

  function automatic logic [3*BITS-1:0] triple(input int s2, input int s1, input int s0);
    return {BITS'(s2), BITS'(s1), BITS'(s0)};
  endfunction

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    a_write_en = 1'b0; a_din = '0; a_read_en = 1'b0; a_flush = 1'b0;
    b_write_en = 1'b0; b_din = '0; b_read_en = 1'b0; b_flush = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkOutput("rst_count", a_count, 0);
    checkOutput("rst_ready", a_ready, 1);
    checkOutput("rst_valid", a_valid, 0);
    checkOutput("rst_err",   a_err,   0);
    checkOutput("rst_b_count", b_count, 0);

    // Case 1: two pushes, one pop
    applyStimulus(1'b1, pair(1, 0), 1'b0, 1'b0);
    checkOutput("c1_valid_low_at_2", a_valid, 0);
    applyStimulus(1'b1, pair(3, 2), 1'b0, 1'b0);
    checkOutput("c1_count4", a_count, 4);
    checkOutput("c1_valid",  a_valid, 1);
    checkOutput("c1_dout",   a_dout,  triple(2, 1, 0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("c1_count1", a_count, 1);
    checkOutput("c1_slice0", a_dout[BITS-1:0], 3);

    // Case 2: fill then overflow attempt
    applyReset();
    applyStimulus(1'b1, pair(1, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(3, 2), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(5, 4), 1'b0, 1'b0);
    checkOutput("c2_count6", a_count, 6);
    checkOutput("c2_ready",  a_ready, 0);
    checkOutput("c2_err_clear", a_err, 0);
    applyStimulus(1'b1, pair(7, 6), 1'b0, 1'b0);
    checkOutput("c2_count_hold", a_count, 6);
    checkOutput("c2_err",        a_err,   1);
    checkOutput("c2_dout_intact", a_dout, triple(2, 1, 0));

    // Case 3: wrap-around
    applyReset();
    checkOutput("c3_err_reset", a_err, 0);
    applyStimulus(1'b1, pair(1, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(3, 2), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(5, 4), 1'b0, 1'b0);
    checkOutput("c3_dout_a", a_dout, triple(2, 1, 0));
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("c3_count3", a_count, 3);
    checkOutput("c3_dout_b", a_dout, triple(5, 4, 3));
    applyStimulus(1'b1, pair(7, 6), 1'b0, 1'b0);
    checkOutput("c3_count5", a_count, 5);
    checkOutput("c3_wr_ptr", u_dut_a.wr_ptr, 2);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("c3_count2", a_count, 2);
    checkOutput("c3_dout_lo", a_dout[2*BITS-1:0], pair(7, 6));
    checkOutput("c3_valid_low", a_valid, 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("c3_count_hold", a_count, 2);
    checkOutput("c3_err_underflow", a_err, 1);
    checkOutput("c3_dout_hold", a_dout[2*BITS-1:0], pair(7, 6));

    // Case 4: simultaneous push and pop
    applyReset();
    applyStimulus(1'b1, pair(1, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(3, 2), 1'b0, 1'b0);
    checkOutput("c4_popped", a_dout, triple(2, 1, 0));
    applyStimulus(1'b1, pair(5, 4), 1'b1, 1'b0);
    checkOutput("c4_count3", a_count, 3);
    checkOutput("c4_dout",   a_dout,  triple(5, 4, 3));
    checkOutput("c4_err",    a_err,   0);

    // Reset mid-operation with a write pending
    a_write_en = 1'b1;
    a_din      = pair(9, 8);
    applyReset();
    a_write_en = 1'b0;
    checkOutput("midrst_count", a_count, 0);
    checkOutput("midrst_valid", a_valid, 0);
    checkOutput("midrst_ready", a_ready, 1);

    // Case 5: flush beats a concurrent write, memory survives
    applyStimulus(1'b1, pair(1, 0), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(3, 2), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(5, 4), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    applyStimulus(1'b1, pair(7, 6), 1'b0, 1'b0);
    applyStimulus(1'b1, pair(9, 8), 1'b0, 1'b0);
    checkOutput("c5_count5", a_count, 5);
    checkOutput("c5_err_set", a_err, 1);
    applyStimulus(1'b1, pair(11, 10), 1'b0, 1'b1);
    checkOutput("c5_count0", a_count, 0);
    checkOutput("c5_err0",   a_err,   0);
    checkOutput("c5_ready",  a_ready, 1);
    checkOutput("c5_valid",  a_valid, 0);
    checkOutput("c5_stale",  a_dout,  triple(2, 7, 6));

    // Case 6: tagged streaming through the 1-in/1-out instance
    for (int k = 0; k < 10; k++) begin
      applyStimulusB(1'b1, wordFor(k), 1'b0);
    end
    checkOutput("c6_count10", b_count, 10);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("c6_word%0d", k), b_dout, wordFor(k));
      checkOutput($sformatf("c6_tag%0d", k), b_dout[BITS-1:BITS-2], tagFor(k));
      applyStimulusB(1'b0, '0, 1'b1);
    end
    checkOutput("c6_empty",  b_count, 0);
    checkOutput("c6_valid0", b_valid, 0);
    checkOutput("c6_err0",   b_err,   0);
    applyStimulusB(1'b0, '0, 1'b1);
    checkOutput("c6_err1",   b_err,   1);
    checkOutput("c6_count_hold", b_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/par_circular_buffer.md
PAR_CIRCULAR_BUFFER -- requirements
Module: par_circular_buffer

Interface
REQ-001 Parameter BITS, default 20, is the width of one word.
REQ-002 Parameter DEPTH, default 60, is the capacity in words; any integer from max(PAR_WRITE,PAR_READ) upward is legal, not only powers of two.
REQ-003 Parameter PAR_WRITE, default 1, is the number of words pushed per accepted write.
REQ-004 Parameter PAR_READ, default 1, is the number of words popped per accepted read.
REQ-005 Parameter CNT_W, default clog2(DEPTH+1), is the width of the occupancy count.
REQ-006 clk  in  1  is the single clock; all state updates on its rising edge.
REQ-007 rst  in  1  is the reset, synchronous and active-high.
REQ-008 write_en  in  1  requests a push of PAR_WRITE words.
REQ-009 din  in  PAR_WRITE*BITS  carries the words to push; slice 0 (LSBs) is the oldest.
REQ-010 read_en  in  1  requests a pop of PAR_READ words.
REQ-011 flush  in  1  empties the buffer.
REQ-012 dout  out  PAR_READ*BITS  carries the PAR_READ oldest words; slice 0 is the oldest.
REQ-013 ready  out  1  is high when free space >= PAR_WRITE.
REQ-014 valid  out  1  is high when count >= PAR_READ.
REQ-015 count  out  CNT_W  is the current occupancy in words.
REQ-016 err  out  1  is a sticky protocol-error flag.

Function
REQ-017 The buffer SHALL accept a write when write_en && ready: words are stored at wr_ptr..wr_ptr+PAR_WRITE-1 modulo DEPTH, wr_ptr advances by PAR_WRITE modulo DEPTH, and count rises by PAR_WRITE.
REQ-018 The buffer SHALL accept a read when read_en && valid: rd_ptr advances by PAR_READ modulo DEPTH, and count falls by PAR_READ.
REQ-019 dout SHALL be first-word-fall-through: it is driven combinationally from mem[rd_ptr+i mod DEPTH], i=0..PAR_READ-1, with zero read latency, and shows stale contents when valid is low.
REQ-020 ready and valid SHALL be combinational from count only and SHALL NOT depend on write_en or read_en in the same cycle.
REQ-021 When a write and a read are accepted in the same cycle, both SHALL take effect, and count SHALL become count+PAR_WRITE-PAR_READ; with DEPTH>=max(PAR_WRITE,PAR_READ) no location is read and written in the same cycle.
REQ-022 A written word SHALL first be visible on dout in the cycle after its write edge.
REQ-023 When write_en is high and ready is low, nothing SHALL be stored and err SHALL be set on the next edge.
REQ-024 When read_en is high and valid is low, pointers SHALL NOT change and err SHALL be set on the next edge.
REQ-025 Pointer wrap SHALL use a compare-and-subtract on the incremented value (p+N>=DEPTH gives p+N-DEPTH), with no modulo operator.
REQ-026 When flush is high, on the next edge wr_ptr, rd_ptr, count and err SHALL all be 0, and any write_en or read_en in that same cycle SHALL be ignored.
REQ-027 Memory contents SHALL NOT be cleared by flush or rst.
REQ-028 When count==DEPTH, ready SHALL be 0; when count==0, valid SHALL be 0.

Reset
REQ-029 When rst is high at a clock edge, wr_ptr, rd_ptr, count and err SHALL become 0, giving ready=1 and valid=0 in the following cycle; rst takes priority over flush, write and read.
REQ-030 Asserting rst mid-operation SHALL discard all stored words; no partial push or pop SHALL occur in that cycle.

Structure
REQ-031 A shared package SHALL hold the clog2 function and default constants (DATA_WIDTH=20, BUF_DEPTH=60) used by the PE-array buffers.
REQ-032 One sub-module, circ_ptr_inc (parameters DEPTH and STEP), SHALL compute the modulo-DEPTH pointer advance; it is instantiated once for wr_ptr and once for rd_ptr.
REQ-033 Storage SHALL be a flat register array of DEPTH x BITS.

Verification (BITS=22, DEPTH=6, PAR_WRITE=2, PAR_READ=3 unless noted)
REQ-034 Case 1: after reset, push {1,0} then {3,2} -> count=4 and valid=1; dout = {2,1,0}; after one pop, count=1 and dout slice0=3.
REQ-035 Case 2: push three times {1,0},{3,2},{5,4} -> count=6 and ready=0; a 4th push with {7,6} -> count stays 6 and err=1.
REQ-036 Case 3 (wrap): fill to 6, pop, push {7,6}, pop, pop -> dout sequence {2,1,0},{5,4,3},{7,6,...}, wr_ptr=2 after the last push, and a final pop shows valid=0 with count=2.
REQ-037 Case 4 (simultaneous): with count=4, write_en and read_en high together -> count=3 and the popped words are the 3 oldest.
REQ-038 Case 5: with count=5 and err=1, assert flush together with write_en -> next cycle count=0, err=0, ready=1, valid=0.
REQ-039 Case 6 (PAR_WRITE=1, PAR_READ=1, DEPTH=60, BITS=22): stream 10 words with 2-bit tags {10,00,...,01} -> all read back in order with tags intact; read_en on empty -> err=1.
